// File: rtl/gcd_top.sv
`default_nettype none
// ============================================================================
// Module      : gcd_top
// Description : Iterative subtractive-Euclid GCD engine, one step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_top #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             done,
    input  logic             clk,
    input  logic             rst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_q;
    logic             r_done;

    logic             w_x_zero;
    logic             w_y_zero;
    logic             w_x_eq_y;
    logic             w_x_gt_y;
    logic [WIDTH-1:0] w_x_minus_y;
    logic [WIDTH-1:0] w_y_minus_x;

    assign w_x_zero    = (r_x == '0);
    assign w_y_zero    = (r_y == '0);
    assign w_x_eq_y    = (r_x == r_y);
    assign w_x_gt_y    = (r_x > r_y);
    // Only the larger-minus-smaller difference is ever committed.
    assign w_x_minus_y = r_x - r_y;
    assign w_y_minus_x = r_y - r_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x     <= a;
                        r_y     <= b;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_x_zero) begin
                        r_q     <= r_y;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_y_zero || w_x_eq_y) begin
                        r_q     <= r_x;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_x_gt_y) begin
                        r_x <= w_x_minus_y;
                    end else begin
                        r_y <= w_y_minus_x;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        r_x     <= a;
                        r_y     <= b;
                        r_done  <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gcd_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_top
// Description : Scoreboard bench for gcd_top with directed vectors and sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_top;

    localparam int WIDTH = 4;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             clk;
    logic             rst;

    gcd_top #(.WIDTH(WIDTH)) dut (
        .a     (a),
        .b     (b),
        .start (start),
        .q     (q),
        .done  (done),
        .clk   (clk),
        .rst   (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        int               lat;
        bit               exact;
        int               load_edge;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   n_total  = 0;
    int   n_pass   = 0;

    always @(posedge clk) edge_cnt++;

    function automatic void check(input string name, input bit ok, input int act, input int exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic int ref_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Monitor: pops an expectation on every rising edge of done.
    initial begin : monitor
        bit   prev_done;
        exp_t e;
        int   lat;
        prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                if (done === 1'b1 && !prev_done) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1'b0, q, 0);
                    end else begin
                        e   = sb.pop_front();
                        lat = edge_cnt - e.load_edge + 1;
                        check("result_q", q === e.q, q, e.q);
                        if (e.exact) check("latency", lat == e.lat, lat, e.lat);
                        else         check("latency_max", lat <= 16, lat, 16);
                    end
                end
                prev_done = (done === 1'b1);
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH-1:0] eq, input int elat,
                          input bit exact, input bit disturb);
        exp_t e;
        bit   got;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.q         = eq;
        e.lat       = elat;
        e.exact     = exact;
        e.load_edge = edge_cnt;
        sb.push_back(e);
        check("done_low_after_load", done === 1'b0, done, 0);
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (disturb && i < 6) begin
                    a     = WIDTH'($urandom);
                    b     = WIDTH'($urandom);
                    start = i[0];
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 1'b0, done, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            repeat (2) begin
                @(negedge clk);
                check("done_held", done === 1'b1, done, 1);
                check("q_held", q === eq, q, eq);
            end
        end
    endtask

    initial begin
        a     = '0;
        b     = '0;
        start = 1'b0;
        rst   = 1'b1;

        // Asynchronous reset before any clock edge
        #3 rst = 1'b0;
        #1;
        check("reset_q", q === 4'd0, q, 0);
        check("reset_done", done === 1'b0, done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("idle_done_low", done === 1'b0, done, 0);
        end

        run_op(4'd15, 4'd2,  4'd1, 10, 1'b1, 1'b0);
        run_op(4'd2,  4'd11, 4'd1, 8,  1'b1, 1'b0);
        run_op(4'd12, 4'd8,  4'd4, 4,  1'b1, 1'b0);
        run_op(4'd9,  4'd9,  4'd9, 2,  1'b1, 1'b0);
        run_op(4'd0,  4'd6,  4'd6, 2,  1'b1, 1'b0);
        run_op(4'd0,  4'd0,  4'd0, 2,  1'b1, 1'b0);
        run_op(4'd15, 4'd1,  4'd1, 16, 1'b1, 1'b0);

        // Inputs disturbed while running must not affect the result
        run_op(4'd15, 4'd2,  4'd1, 10, 1'b1, 1'b1);

        // Reset in the middle of a run aborts it
        @(negedge clk);
        a     = 4'd15;
        b     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_q", q === 4'd0, q, 0);
        check("abort_done", done === 1'b0, done, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_idle_done", done === 1'b0, done, 0);
        end

        run_op(4'd6, 4'd4, 4'd2, 4, 1'b1, 1'b0);

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run_op(WIDTH'(ai), WIDTH'(bi), WIDTH'(ref_gcd(ai, bi)), 0, 1'b0, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
